// File: rtl/ctrl_pipe_chain_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_chain_if
//
// Bundles the ID-side inputs and the per-stage outputs of ctrl_pipe_chain.
//   master : control unit / datapath side (drives ID word, freeze, flush)
//   slave  : the pipeline chain itself
//
// Signals
//   id_ctrl, id_valid, nop_sel  ID mux word, real-instruction flag, bubble select
//   freeze                      hold the whole chain
//   flush[STAGES]               per-stage clear mask
//   stage_ctrl, stage_valid     flattened stage words and valid bits
//   wb_ctrl                     last-stage word
//   occupancy, retire           valid-count and "last stage leaves this cycle"
//   load_use_hint               stage 0 holds a valid load
//   retired_cnt, bubble_cnt     perf counters, only with CTRL_PIPE_PERF_EN
// ---------------------------------------------------------------------------
interface ctrl_pipe_chain_if #(
    parameter int unsigned CTRL_W = 18,
    parameter int unsigned STAGES = 3
);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [CTRL_W-1:0]        id_ctrl;
    logic                     id_valid;
    logic                     nop_sel;
    logic                     freeze;
    logic [STAGES-1:0]        flush;
    logic [STAGES*CTRL_W-1:0] stage_ctrl;
    logic [STAGES-1:0]        stage_valid;
    logic [CTRL_W-1:0]        wb_ctrl;
    logic [OCC_W-1:0]         occupancy;
    logic                     retire;
    logic                     load_use_hint;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]              retired_cnt;
    logic [31:0]              bubble_cnt;

    modport master (
        output id_ctrl, id_valid, nop_sel, freeze, flush,
        input  stage_ctrl, stage_valid, wb_ctrl, occupancy, retire, load_use_hint,
        input  retired_cnt, bubble_cnt
    );

    modport slave (
        input  id_ctrl, id_valid, nop_sel, freeze, flush,
        output stage_ctrl, stage_valid, wb_ctrl, occupancy, retire, load_use_hint,
        output retired_cnt, bubble_cnt
    );
`else
    modport master (
        output id_ctrl, id_valid, nop_sel, freeze, flush,
        input  stage_ctrl, stage_valid, wb_ctrl, occupancy, retire, load_use_hint
    );

    modport slave (
        input  id_ctrl, id_valid, nop_sel, freeze, flush,
        output stage_ctrl, stage_valid, wb_ctrl, occupancy, retire, load_use_hint
    );
`endif
endinterface

// File: rtl/ctrl_pipe_chain.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_chain
//
// Carries decoded control words from the ID mux through STAGES stage
// registers (0 = EX ... STAGES-1 = WB). Each stage has a valid bit; the chain
// supports whole-chain freeze, per-stage flush (flush beats freeze), bubble
// insertion at stage 0, occupancy/retire reporting and a load-use hint.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ctrl_pipe_chain_if.slave (ID inputs, freeze/flush, stage outputs)
//
// Optional feature: define CTRL_PIPE_PERF_EN to add the 32-bit retired_cnt and
// bubble_cnt counters on the interface.
// ---------------------------------------------------------------------------
module ctrl_pipe_chain #(
    parameter int unsigned       CTRL_W   = 18,
    parameter int unsigned       STAGES   = 3,
    parameter logic [CTRL_W-1:0] BUBBLE   = {CTRL_W{1'b0}},
    parameter int unsigned       LOAD_BIT = 9
) (
    input  logic              clk,
    input  logic              reset,
    ctrl_pipe_chain_if.slave  bus
);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [CTRL_W-1:0] word_q [STAGES];
    logic [CTRL_W-1:0] word_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [OCC_W-1:0]  occ;
    logic              retire;

    // Next-state: flush first, then freeze-hold, then shift.
    always_comb begin
        word_d[0]  = word_q[0];
        valid_d[0] = valid_q[0];
        if (bus.flush[0]) begin
            word_d[0]  = BUBBLE;
            valid_d[0] = 1'b0;
        end else if (!bus.freeze) begin
            if (bus.nop_sel || !bus.id_valid) begin
                word_d[0]  = BUBBLE;
                valid_d[0] = 1'b0;
            end else begin
                word_d[0]  = bus.id_ctrl;
                valid_d[0] = 1'b1;
            end
        end

        for (int i = 1; i < STAGES; i++) begin
            word_d[i]  = word_q[i];
            valid_d[i] = valid_q[i];
            if (bus.flush[i]) begin
                word_d[i]  = BUBBLE;
                valid_d[i] = 1'b0;
            end else if (!bus.freeze) begin
                word_d[i]  = word_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= BUBBLE;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= word_d[i];
            end
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_flat
        assign bus.stage_ctrl[g*CTRL_W +: CTRL_W] = word_q[g];
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign retire            = valid_q[STAGES-1] & ~bus.freeze;
    assign bus.stage_valid   = valid_q;
    assign bus.wb_ctrl       = word_q[STAGES-1];
    assign bus.occupancy     = occ;
    assign bus.retire        = retire;
    assign bus.load_use_hint = valid_q[0] & word_q[0][LOAD_BIT];

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        stage0_bubble;

    // Only unfrozen edges count; a frozen flush[0] is not a new bubble slot.
    assign stage0_bubble = ~bus.freeze & (bus.flush[0] | bus.nop_sel | ~bus.id_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt_q <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_q + 32'(retire);
            bubble_cnt_q  <= bubble_cnt_q + 32'(stage0_bubble);
        end
    end

    assign bus.retired_cnt = retired_cnt_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
`else
    // Perf counters not built.
`endif
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_chain
//
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based model of the chain (push a new slot at the front on every
// unfrozen edge, drop the oldest, then apply the flush mask).
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_chain;
    localparam int unsigned   CW  = 18;
    localparam int unsigned   S   = 3;
    localparam int unsigned   LB  = 9;
    localparam logic [CW-1:0] BUB = '0;

    localparam logic [CW-1:0] WA = 18'h00201;
    localparam logic [CW-1:0] WB = 18'h00402;
    localparam logic [CW-1:0] WC = 18'h00803;
    localparam logic [CW-1:0] WD = 18'h01204;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe_chain_if #(.CTRL_W(CW), .STAGES(S)) bus ();

    ctrl_pipe_chain #(
        .CTRL_W   (CW),
        .STAGES   (S),
        .BUBBLE   (BUB),
        .LOAD_BIT (LB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [CW-1:0] m_word  [$];
    bit            m_valid [$];
    int unsigned   m_ret;
    int unsigned   m_bub;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_word.delete();
        m_valid.delete();
        for (int i = 0; i < S; i++) begin
            m_word.push_back(BUB);
            m_valid.push_back(1'b0);
        end
        m_ret = 0;
        m_bub = 0;
    endtask

    // Called at the rising edge, with the inputs the DUT samples.
    task automatic model_edge();
        logic [CW-1:0] nw;
        bit            nv;
        if (!reset) return;
        if (m_valid[S-1] && !bus.freeze) m_ret++;
        if (!bus.freeze) begin
            if (bus.flush[0] || bus.nop_sel || !bus.id_valid) begin
                nw = BUB;
                nv = 1'b0;
                m_bub++;
            end else begin
                nw = bus.id_ctrl;
                nv = 1'b1;
            end
            m_word.push_front(nw);
            m_valid.push_front(nv);
            void'(m_word.pop_back());
            void'(m_valid.pop_back());
        end
        for (int i = 0; i < S; i++) begin
            if (bus.flush[i]) begin
                m_word[i]  = BUB;
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        int unsigned occ;
        occ = 0;
        for (int i = 0; i < S; i++) begin
            check("stage_word", bus.stage_ctrl[i*CW +: CW], m_word[i]);
            check("stage_valid", bus.stage_valid[i], m_valid[i]);
            if (m_valid[i]) occ++;
        end
        check("wb_ctrl", bus.wb_ctrl, m_word[S-1]);
        check("occupancy", bus.occupancy, occ);
        check("retire", bus.retire, m_valid[S-1] && !bus.freeze);
        check("load_use_hint", bus.load_use_hint, m_valid[0] && m_word[0][LB]);
`ifdef CTRL_PIPE_PERF_EN
        check("retired_cnt", bus.retired_cnt, m_ret);
        check("bubble_cnt", bus.bubble_cnt, m_bub);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic [CW-1:0] c, input logic v, input logic nop,
                         input logic frz, input logic [S-1:0] fl);
        bus.id_ctrl  = c;
        bus.id_valid = v;
        bus.nop_sel  = nop;
        bus.freeze   = frz;
        bus.flush    = fl;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_valid_now", bus.stage_valid, '0);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        drive(18'h3FFFF, 1'b1, 1'b0, 1'b0, '0);
        #1;
        check_outputs();

        // Reset held for 3 edges with a live word at ID.
        for (int i = 0; i < 3; i++) step();
        check("rst_occ", bus.occupancy, 0);
        reset = 1'b1;
        step();
        step();
        check("lat_early", bus.stage_valid[S-1], 1'b0);
        step();
        check("lat_wb", bus.wb_ctrl, 18'h3FFFF);
        check("lat_wb_valid", bus.stage_valid[S-1], 1'b1);

        // Stream A, B, C on consecutive edges.
        pulse_reset();
        drive(WA, 1'b1, 1'b0, 1'b0, '0);
        step();
        check("occ_ramp1", bus.occupancy, 1);
        check("lu_a", bus.load_use_hint, 1'b1);
        drive(WB, 1'b1, 1'b0, 1'b0, '0);
        step();
        check("occ_ramp2", bus.occupancy, 2);
        check("lu_b", bus.load_use_hint, 1'b0);
        drive(WC, 1'b1, 1'b0, 1'b0, '0);
        step();
        check("occ_ramp3", bus.occupancy, 3);
        check("wb_a", bus.wb_ctrl, WA);
        check("ret_a", bus.retire, 1'b1);
        drive(WD, 1'b0, 1'b0, 1'b0, '0);
        step();
        check("wb_b", bus.wb_ctrl, WB);
        check("ret_b", bus.retire, 1'b1);
        step();
        check("wb_c", bus.wb_ctrl, WC);
        check("ret_c", bus.retire, 1'b1);
        step();
        check("ret_done", bus.retire, 1'b0);

        // Bubble in the middle of a stream.
        drive(WA, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WB, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WD, 1'b1, 1'b1, 1'b0, '0); step();
        check("bub_stage0", bus.stage_ctrl[CW-1:0], BUB);
        drive(WC, 1'b1, 1'b0, 1'b0, '0); step();
        check("bub_occ", bus.occupancy, 2);
        drive(WD, 1'b1, 1'b0, 1'b0, '0); step();
        check("bub_wb_valid", bus.stage_valid[S-1], 1'b0);
        check("bub_wb_word", bus.wb_ctrl, BUB);

        // Freeze for 2 cycles with a full chain.
        drive(WA, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WB, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WC, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WD, 1'b1, 1'b0, 1'b1, '0);
        #1;
        check("frz_retire", bus.retire, 1'b0);
        step();
        step();
        check("frz_wb", bus.wb_ctrl, WA);
        check("frz_ret0", bus.retire, 1'b0);
        drive(WD, 1'b1, 1'b0, 1'b0, '0); step();
        check("frz_resume_b", bus.wb_ctrl, WB);
        drive(WD, 1'b0, 1'b0, 1'b0, '0); step();
        check("frz_resume_c", bus.wb_ctrl, WC);
        step();
        check("frz_resume_d", bus.wb_ctrl, WD);

        // Flush stages 0 and 1 while frozen.
        drive(WA, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WB, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WC, 1'b1, 1'b0, 1'b0, '0); step();
        drive(WD, 1'b1, 1'b0, 1'b1, 3'b011); step();
        check("flf_valid", bus.stage_valid, 3'b100);
        check("flf_wb", bus.wb_ctrl, WA);
        drive(WD, 1'b0, 1'b0, 1'b0, '0); step();
        check("flf_shift", bus.stage_valid, 3'b000);

`ifdef CTRL_PIPE_PERF_EN
        // 15 edges, nops on edges 4 and 7: 10 words retired, 2 bubbles.
        pulse_reset();
        for (int e = 1; e <= 15; e++) begin
            drive(CW'(e), 1'b1, (e == 4 || e == 7), 1'b0, '0);
            step();
        end
        check("perf_retired", bus.retired_cnt, 10);
        check("perf_bubble", bus.bubble_cnt, 2);
        pulse_reset();
        check("perf_clr_ret", bus.retired_cnt, 0);
        check("perf_clr_bub", bus.bubble_cnt, 0);
`endif

        // Randomized traffic with one mid-run reset.
        for (int n = 0; n < 600; n++) begin
            drive(CW'($urandom),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0) ? S'($urandom) : '0);
            if (n == 300) pulse_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
